// File: rtl/binarytobcd_serial.sv
// binarytobcd_serial
//   Converts one unsigned binary word to packed BCD by shift-add-3
//   (double dabble), one bit per clock, then streams the digits out
//   most-significant first over a valid/ready handshake.
//
// Parameters:
//   WIDTH  - binary input width (default 8)
//   DIGITS - BCD digits produced; requires 10**DIGITS > 2**WIDTH-1 (default 3)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   load        in   start request, sampled only while busy=0
//   in          in   [WIDTH-1:0] binary value captured on accepted load
//   busy        out  conversion or digit stream in progress
//   digit_out   out  [3:0] current BCD digit (valid with digit_valid)
//   digit_valid out  digit_out holds a digit to transfer
//   digit_ready in   consumer accepts digit on this edge
//   digit_last  out  final digit of the current result
//   bcd_out     out  [4*DIGITS-1:0] packed BCD of last completed conversion
//
// Build option:
//   BCD_SUPPRESS_LEADING_ZEROS_EN - when defined, the stream starts at the
//   highest nonzero digit (a value of 0 emits a single 0). bcd_out always
//   carries the full zero-padded result.
module binarytobcd_serial #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WIDTH-1:0]      in,
  output logic                  busy,
  output logic [3:0]            digit_out,
  output logic                  digit_valid,
  input  logic                  digit_ready,
  output logic                  digit_last,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [WIDTH-1:0] r_bin,     w_bin_nx;
  logic [BW-1:0]    r_bcd,     w_bcd_nx;
  logic [CW-1:0]    r_cnt,     w_cnt_nx;
  logic [PW-1:0]    r_ptr,     w_ptr_nx;
  logic [BW-1:0]    r_bcd_out, w_bcd_out_nx;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_bcd_sh;
  logic [WIDTH-1:0] w_bin_sh;
  logic [PW-1:0]    w_top_ptr;
  logic [3:0]       w_digit;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  // The top accumulator bit is shifted out; for legal WIDTH/DIGITS it is
  // always zero, so a set bit here means the parameters are out of range.
  always_comb begin
    if (r_state == CONVERT) begin
      assert (!w_adj[BW-1]);
    end
  end

  assign w_bcd_sh = {w_adj[BW-2:0], r_bin[WIDTH-1]};
  assign w_bin_sh = {r_bin[WIDTH-2:0], 1'b0};

  // Starting digit of the stream, taken from the just-finished result.
`ifdef BCD_SUPPRESS_LEADING_ZEROS_EN
  always_comb begin
    w_top_ptr = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (w_bcd_sh[4*d +: 4] != 4'd0) begin
        w_top_ptr = PW'(d);
      end
    end
  end
`else
  assign w_top_ptr = PW'(DIGITS - 1);
`endif

  // Digit currently selected by the stream pointer.
  always_comb begin
    w_digit = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_ptr == PW'(d)) begin
        w_digit = r_bcd_out[4*d +: 4];
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_bin_nx     = r_bin;
    w_bcd_nx     = r_bcd;
    w_cnt_nx     = r_cnt;
    w_ptr_nx     = r_ptr;
    w_bcd_out_nx = r_bcd_out;
    unique case (r_state)
      IDLE: begin
        if (load) begin
          w_bin_nx   = in;
          w_bcd_nx   = '0;
          w_cnt_nx   = CW'(WIDTH);
          w_state_nx = CONVERT;
        end
      end
      CONVERT: begin
        w_bin_nx = w_bin_sh;
        w_bcd_nx = w_bcd_sh;
        w_cnt_nx = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_bcd_out_nx = w_bcd_sh;
          w_ptr_nx     = w_top_ptr;
          w_state_nx   = SEND;
        end
      end
      SEND: begin
        if (digit_ready) begin
          if (r_ptr == '0) begin
            w_state_nx = IDLE;
          end else begin
            w_ptr_nx = r_ptr - PW'(1);
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_bcd_out <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_bin     <= w_bin_nx;
      r_bcd     <= w_bcd_nx;
      r_cnt     <= w_cnt_nx;
      r_ptr     <= w_ptr_nx;
      r_bcd_out <= w_bcd_out_nx;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears
  // them without waiting for a clock edge.
  assign busy        = (r_state != IDLE);
  assign digit_valid = (r_state == SEND);
  assign digit_last  = (r_state == SEND) && (r_ptr == '0);
  assign digit_out   = (r_state == SEND) ? w_digit : 4'd0;
  assign bcd_out     = r_bcd_out;

endmodule

// File: tb/tb_binarytobcd_serial.sv
module tb_binarytobcd_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [7:0]  bin;
  logic        busy;
  logic [3:0]  digit_out;
  logic        digit_valid;
  logic        digit_ready;
  logic        digit_last;
  logic [11:0] bcd_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binarytobcd_serial #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .in          (bin),
    .busy        (busy),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit_last  (digit_last),
    .bcd_out     (bcd_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Pulse load for one edge; caller is positioned just after an edge.
  task automatic start(input logic [7:0] v);
    load = 1'b1;
    bin  = v;
    step();
    load = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !digit_valid; i++) step();
    chk(tag, digit_valid, 1);
  endtask

  // Collect the digit stream for value v and compare against the decimal model.
  task automatic expect_stream(input int v, input bit rnd);
    logic [11:0] e;
    int first;
    int idx;
    int got;
    bit done;
    e     = ref_bcd(v);
    first = 2;
`ifdef BCD_SUPPRESS_LEADING_ZEROS_EN
    first = (v >= 100) ? 2 : (v >= 10) ? 1 : 0;
`endif
    idx  = first;
    got  = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      digit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (digit_valid && digit_ready) begin
        got++;
        if (idx >= 0) begin
          chk($sformatf("digit v=%0d i=%0d", v, idx), digit_out, e[4*idx +: 4]);
          chk($sformatf("last v=%0d i=%0d", v, idx), digit_last, (idx == 0));
        end
        if (idx == 0) done = 1'b1;
        idx--;
      end
      step();
    end
    digit_ready = 1'b0;
    chk($sformatf("ndigits v=%0d", v), got, first + 1);
    chk($sformatf("busy_end v=%0d", v), busy, 0);
    chk($sformatf("valid_end v=%0d", v), digit_valid, 0);
    chk($sformatf("bcd_out v=%0d", v), bcd_out, e);
  endtask

  // Load v and verify the WIDTH-cycle conversion latency.
  task automatic start_timed(input logic [7:0] v, input string tag);
    start(v);
    chk({tag, "_busy"}, busy, 1);
    for (int k = 1; k < 8; k++) begin
      step();
      chk($sformatf("%s_lat%0d", tag, k), digit_valid, 0);
    end
    step();
    chk({tag, "_lat8"}, digit_valid, 1);
    chk({tag, "_bcd"}, bcd_out, ref_bcd(int'(v)));
  endtask

  initial begin
    reset       = 1'b0;
    load        = 1'b0;
    bin         = '0;
    digit_ready = 1'b0;
    #1;
    chk("rst_busy",  busy, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_last",  digit_last, 0);
    chk("rst_digit", digit_out, 0);
    chk("rst_bcd",   bcd_out, 0);
    step();
    step();
    reset = 1'b1;
    step();

    // 255 with constant ready
    start_timed(8'd255, "v255");
    expect_stream(255, 1'b0);

    // small values: leading zeros
    start(8'd9);
    wait_valid("v9_wait");
    expect_stream(9, 1'b0);
    start(8'd0);
    wait_valid("v0_wait");
    expect_stream(0, 1'b0);

    // backpressure on 128
    start(8'd128);
    wait_valid("v128_wait");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold_digit%0d", k), digit_out, 1);
      chk($sformatf("hold_valid%0d", k), digit_valid, 1);
      chk($sformatf("hold_last%0d", k), digit_last, 0);
      step();
    end
    expect_stream(128, 1'b0);

    // load ignored while busy
    start(8'd100);
    step();
    step();
    load = 1'b1;
    bin  = 8'd37;
    step();
    load = 1'b0;
    wait_valid("v100_wait");
    load = 1'b1;
    step();
    step();
    load = 1'b0;
    chk("v100_first", digit_out, 1);
    expect_stream(100, 1'b0);
    step();
    step();
    chk("v100_idle_busy", busy, 0);
    chk("v100_idle_bcd", bcd_out, 12'h100);
    start(8'd37);
    wait_valid("v37_wait");
    expect_stream(37, 1'b0);

    // asynchronous reset during CONVERT
    start(8'd200);
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("rc_busy",  busy, 0);
    chk("rc_valid", digit_valid, 0);
    chk("rc_bcd",   bcd_out, 0);
    step();
    reset = 1'b1;
    step();
    // asynchronous reset during SEND
    start(8'd77);
    wait_valid("v77_wait");
    chk("v77_bcd", bcd_out, 12'h077);
    #2 reset = 1'b0;
    #1;
    chk("rs_busy",  busy, 0);
    chk("rs_valid", digit_valid, 0);
    chk("rs_last",  digit_last, 0);
    chk("rs_digit", digit_out, 0);
    chk("rs_bcd",   bcd_out, 0);
    step();
    reset = 1'b1;
    step();
    start_timed(8'd42, "v42");
    expect_stream(42, 1'b0);

    // full sweep, back-to-back loads, random ready
    for (int v = 0; v < 256; v++) begin
      start(8'(v));
      wait_valid($sformatf("sweep_wait%0d", v));
      expect_stream(v, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binarytobcd_serial.md
Name: binarytobcd_serial

Overview:
- Reverse direction of the team's serial BCD-to-binary loader.
- Accepts one unsigned binary word, converts it to packed BCD by iterative shift-add-3 (double dabble), one bit per clock.
- Streams the result out one 4-bit BCD digit per transfer, most-significant digit first, over a valid/ready handshake.
- Sits between binary arithmetic and display/serial digit consumers; also exposes the full packed BCD result.

Parameters:
- WIDTH, 8, bit width of the binary input.
- DIGITS, 3, number of BCD digits produced. Legal only when 10^DIGITS > 2^WIDTH-1; 8/3 is the supported default.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when 0.
- load  input  1  start request; sampled only while busy=0.
- in  input  WIDTH  unsigned binary value, captured on the accepted load edge.
- busy  output  1  high from the cycle after an accepted load until the last digit transfer completes.
- digit_out  output  4  current BCD digit, valid when digit_valid=1.
- digit_valid  output  1  digit_out holds a digit to transfer.
- digit_ready  input  1  consumer accepts; a transfer occurs on an edge where digit_valid&&digit_ready.
- digit_last  output  1  high with the final digit of the current result.
- bcd_out  output  4*DIGITS  packed BCD of the last completed conversion; digit 0 in [3:0].

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, digit_valid, digit_last=0; digit_out=0; bcd_out=0; shift/counter registers cleared. Takes effect mid-conversion or mid-stream; the partial result is discarded and nothing further is emitted.
- States: IDLE, CONVERT, SEND.
- IDLE:
  - On an edge with load=1, capture in into the binary shift register.
  - Clear the BCD accumulator and set the bit counter to WIDTH.
  - Go to CONVERT; busy=1.
- CONVERT, one step per edge:
  - For each BCD nibble >=5, add 3.
  - Then shift {bcd, bin} left by 1 and decrement the counter.
  - After exactly WIDTH steps, write the accumulator to bcd_out and enter SEND.
- Latency:
  - load accepted at edge N.
  - Shifts occur on edges N+1..N+WIDTH.
  - digit_valid=1 and bcd_out updated after edge N+WIDTH.
- SEND:
  - digit_valid=1; digit_out = the current digit, starting with digit DIGITS-1.
  - On each transfer, advance to the next lower digit.
  - digit_last=1 while digit 0 is presented.
  - digit_out and digit_last hold stable while digit_ready=0; no timeout.
  - Transfer of the last digit returns to IDLE on the same edge: busy=0, digit_valid=0, digit_last=0.
- load while busy=1 is ignored; in is not sampled.
- A new load can be accepted on the first edge after the return to IDLE, so back-to-back conversions are WIDTH+DIGITS+1 cycles apart at full throughput.
- bcd_out holds its value until the next conversion completes, including through SEND and IDLE.
- in values are always representable; there is no overflow case for legal parameters.

Optional Feature:
- Macro BCD_SUPPRESS_LEADING_ZEROS_EN.
- Defined:
  - On entering SEND, the digit pointer starts at the highest nonzero digit.
  - Leading zero digits are never presented.
  - A value of 0 emits the single digit 0 with digit_last=1.
  - bcd_out is unaffected and still carries the full zero-padded result.
- Undefined: exactly DIGITS digits are always emitted, including leading zeros.

Test Plan:
- in=255, load pulse, digit_ready=1 constant -> bcd_out=12'h255 after 8 cycles; digits 2,5,5 on consecutive cycles; digit_last only with the 5 of digit 0; busy low after the 3rd transfer.
- in=9 and in=0, macro undefined -> streams 0,0,9 and 0,0,0. Macro defined -> 9 alone and 0 alone, each with digit_last=1; bcd_out=12'h009 / 12'h000.
- in=128, digit_ready low for 4 cycles after digit_valid rises -> digit_out stays 1, digit_valid stays 1; then digits 1,2,8 transfer once each; no duplicate or dropped digit.
- in=100 loaded, then load=1 with in=37 during CONVERT and during SEND -> only 1,0,0 emitted; 37 is converted only if load is reasserted after busy=0.
- reset driven low between clock edges during CONVERT and again during SEND -> all outputs 0 immediately; following load of in=42 yields 0,4,2 with normal 8-cycle latency.
- Sweep in=0..255 with random digit_ready -> each digit sequence and bcd_out match a decimal reference model.
